// File: rtl/result_track_pipe_if.sv
// Forwarding-producer bus for result_track_pipe.
// EX/decode inputs and MEM/WB tracking outputs.
interface result_track_pipe_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] rd_ex;
  logic                  reg_write_ex;
  logic                  mem_read_ex;
  logic [XLEN-1:0]       alu_result_ex;
  logic [XLEN-1:0]       load_data_mem;
  logic                  stall_mem;
  logic                  flush_ex;
  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic [REG_ADDR_W-1:0] rd_mem;
  logic                  reg_write_mem;
  logic                  mem_read_mem;
  logic [XLEN-1:0]       fwd_data_mem;
  logic [REG_ADDR_W-1:0] rd_wb;
  logic                  reg_write_wb;
  logic [XLEN-1:0]       wb_data;
  logic                  load_use_stall;
  logic [CNT_W-1:0]      retired_writes;

  modport slave (
    input  ex_valid, rd_ex, reg_write_ex,
    input  mem_read_ex, alu_result_ex,
    input  load_data_mem, stall_mem, flush_ex,
    input  rs1_id, rs2_id,
    output rd_mem, reg_write_mem, mem_read_mem,
    output fwd_data_mem, rd_wb, reg_write_wb,
    output wb_data, load_use_stall, retired_writes
  );

  modport master (
    output ex_valid, rd_ex, reg_write_ex,
    output mem_read_ex, alu_result_ex,
    output load_data_mem, stall_mem, flush_ex,
    output rs1_id, rs2_id,
    input  rd_mem, reg_write_mem, mem_read_mem,
    input  fwd_data_mem, rd_wb, reg_write_wb,
    input  wb_data, load_use_stall, retired_writes
  );
endinterface

// File: rtl/result_track_pipe.sv
// EX/MEM and MEM/WB destination tracking for forwarding,
// load-use hazard detect and retired-write counter.
module result_track_pipe #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  result_track_pipe_if.slave bus
);

  logic [REG_ADDR_W-1:0] rd_m;
  logic                  we_m;
  logic                  ld_m;
  logic [XLEN-1:0]       dat_m;
  logic [REG_ADDR_W-1:0] rd_w;
  logic                  we_w;
  logic [XLEN-1:0]       dat_w;
  logic [CNT_W-1:0]      cnt;
  logic                  rd_nz;
  logic                  live;
  logic                  hit;
  logic                  lus;

  assign rd_nz = |bus.rd_ex;
  assign live  = bus.ex_valid & ~bus.flush_ex;

  // EX/MEM register; frozen while data memory waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_m  <= '0;
      we_m  <= 1'b0;
      ld_m  <= 1'b0;
      dat_m <= '0;
    end else if (!bus.stall_mem) begin
      rd_m  <= bus.rd_ex;
      we_m  <= live & bus.reg_write_ex & rd_nz;
      ld_m  <= live & bus.mem_read_ex;
      dat_m <= bus.alu_result_ex;
    end
  end

  // MEM/WB register; a stall injects a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_w  <= '0;
      we_w  <= 1'b0;
      dat_w <= '0;
    end else if (!bus.stall_mem) begin
      rd_w  <= rd_m;
      we_w  <= we_m;
      dat_w <= ld_m ? bus.load_data_mem : dat_m;
    end else begin
      we_w  <= 1'b0;
    end
  end

  // Count committed register-file writes, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (we_w) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Load-use hazard; a MEM stall also freezes decode
  always_comb begin
    hit = (bus.rd_ex == bus.rs1_id) |
          (bus.rd_ex == bus.rs2_id);
    lus = live & bus.mem_read_ex &
          bus.reg_write_ex & rd_nz & hit;
    lus = (lus | bus.stall_mem) & ~rst;
  end

  assign bus.rd_mem         = rd_m;
  assign bus.reg_write_mem  = we_m;
  assign bus.mem_read_mem   = ld_m;
  assign bus.fwd_data_mem   = dat_m;
  assign bus.rd_wb          = rd_w;
  assign bus.reg_write_wb   = we_w;
  assign bus.wb_data        = dat_w;
  assign bus.load_use_stall = lus;
  assign bus.retired_writes = cnt;

endmodule

// File: tb/tb_result_track_pipe.sv
// Self-checking bench for result_track_pipe.
// Table vectors for hazard logic, scoreboard for writes.
module tb_result_track_pipe;

  logic clk;
  logic rst;

  result_track_pipe_if #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(32)) bus ();
  result_track_pipe_if #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(4))  bsm ();

  result_track_pipe #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  result_track_pipe #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .bus(bsm)
  );

  assign bsm.ex_valid      = bus.ex_valid;
  assign bsm.rd_ex         = bus.rd_ex;
  assign bsm.reg_write_ex  = bus.reg_write_ex;
  assign bsm.mem_read_ex   = bus.mem_read_ex;
  assign bsm.alu_result_ex = bus.alu_result_ex;
  assign bsm.load_data_mem = bus.load_data_mem;
  assign bsm.stall_mem     = bus.stall_mem;
  assign bsm.flush_ex      = bus.flush_ex;
  assign bsm.rs1_id        = bus.rs1_id;
  assign bsm.rs2_id        = bus.rs2_id;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       mr;
    logic       fl;
    logic       st;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       lus;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  int   nvec;
  int   nfail;
  int   exp_writes;
  logic mon_en;
  wr_t  sb[$];
  vec_t tbl[10];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic v, input logic [4:0] rd,
                    input logic we, input logic mr,
                    input logic [63:0] alu,
                    input logic fl, input logic st);
    bus.ex_valid      = v;
    bus.rd_ex         = rd;
    bus.reg_write_ex  = we;
    bus.mem_read_ex   = mr;
    bus.alu_result_ex = alu;
    bus.flush_ex      = fl;
    bus.stall_mem     = st;
  endtask

  task automatic idle();
    ex(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [4:0] rd,
                      input logic [63:0] d);
    wr_t w;
    w.rd   = rd;
    w.data = d;
    sb.push_back(w);
    exp_writes++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_mem"},  64'(bus.rd_mem), 64'd0);
    chk({tag, "_we_mem"},  64'(bus.reg_write_mem), 64'd0);
    chk({tag, "_ld_mem"},  64'(bus.mem_read_mem), 64'd0);
    chk({tag, "_fwd_mem"}, bus.fwd_data_mem, 64'd0);
    chk({tag, "_rd_wb"},   64'(bus.rd_wb), 64'd0);
    chk({tag, "_we_wb"},   64'(bus.reg_write_wb), 64'd0);
    chk({tag, "_wb_data"}, bus.wb_data, 64'd0);
    chk({tag, "_cnt"},     64'(bus.retired_writes), 64'd0);
    chk({tag, "_cnt_sm"},  64'(bsm.retired_writes), 64'd0);
  endtask

  // Scoreboard monitor: every WB write must match the queue head
  always @(posedge clk) begin
    #1;
    if (mon_en && !rst && bus.reg_write_wb) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", 64'(bus.rd_wb), 64'd0);
      end else begin
        wr_t w;
        w = sb.pop_front();
        chk("sb_rd", 64'(bus.rd_wb), 64'(w.rd));
        chk("sb_data", bus.wb_data, w.data);
      end
    end
  end

  initial begin
    nvec       = 0;
    nfail      = 0;
    exp_writes = 0;
    mon_en     = 1'b0;
    rst        = 1'b1;
    idle();
    bus.load_data_mem = 64'd0;
    bus.rs1_id        = 5'd0;
    bus.rs2_id        = 5'd0;

    tbl[0] = '{1, 7, 1, 1, 0, 0, 7, 0, 1};
    tbl[1] = '{1, 7, 1, 1, 0, 0, 0, 7, 1};
    tbl[2] = '{1, 7, 1, 1, 0, 0, 3, 4, 0};
    tbl[3] = '{0, 7, 1, 1, 0, 0, 7, 7, 0};
    tbl[4] = '{1, 7, 0, 1, 0, 0, 7, 0, 0};
    tbl[5] = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 7, 1, 1, 1, 0, 7, 0, 0};
    tbl[7] = '{1, 7, 1, 1, 1, 1, 7, 0, 1};
    tbl[8] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[9] = '{1, 7, 1, 0, 0, 0, 7, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset_lus", 64'(bus.load_use_stall), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      ex(tbl[i].v, tbl[i].rd, tbl[i].we, tbl[i].mr,
         64'h100, tbl[i].fl, tbl[i].st);
      bus.rs1_id = tbl[i].rs1;
      bus.rs2_id = tbl[i].rs2;
      #1;
      chk($sformatf("lus_vec%0d", i),
          64'(bus.load_use_stall), 64'(tbl[i].lus));
      tick();
    end
    idle();
    bus.rs1_id = 5'd0;
    bus.rs2_id = 5'd0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // back-to-back ALU writes
    ex(1, 5'd5, 1, 0, 64'h11, 0, 0);
    push(5'd5, 64'h11);
    tick();
    chk("b2b_rd_mem", 64'(bus.rd_mem), 64'd5);
    chk("b2b_we_mem", 64'(bus.reg_write_mem), 64'd1);
    chk("b2b_fwd_mem", bus.fwd_data_mem, 64'h11);
    ex(1, 5'd6, 1, 0, 64'h22, 0, 0);
    push(5'd6, 64'h22);
    tick();
    chk("b2b_rd_wb0", 64'(bus.rd_wb), 64'd5);
    chk("b2b_wb0", bus.wb_data, 64'h11);
    idle();
    tick();
    chk("b2b_rd_wb1", 64'(bus.rd_wb), 64'd6);
    chk("b2b_wb1", bus.wb_data, 64'h22);
    tick();
    chk("b2b_cnt", 64'(bus.retired_writes), 64'(exp_writes));

    // write to x0 is suppressed
    ex(1, 5'd0, 1, 0, 64'h33, 0, 0);
    tick();
    chk("x0_we_mem", 64'(bus.reg_write_mem), 64'd0);
    idle();
    tick();
    chk("x0_we_wb", 64'(bus.reg_write_wb), 64'd0);
    tick();
    chk("x0_cnt", 64'(bus.retired_writes), 64'(exp_writes));

    // load with dependent decode
    ex(1, 5'd7, 1, 1, 64'h1000, 0, 0);
    bus.rs1_id = 5'd7;
    push(5'd7, 64'hDEAD_BEEF_0000_0001);
    #1;
    chk("ld_lus", 64'(bus.load_use_stall), 64'd1);
    tick();
    chk("ld_mr_mem", 64'(bus.mem_read_mem), 64'd1);
    idle();
    bus.rs1_id = 5'd0;
    bus.load_data_mem = 64'hDEAD_BEEF_0000_0001;
    #1;
    chk("ld_lus_off", 64'(bus.load_use_stall), 64'd0);
    tick();
    chk("ld_wb_data", bus.wb_data, 64'hDEAD_BEEF_0000_0001);
    bus.load_data_mem = 64'd0;
    tick();

    // three-cycle memory stall with x8 in MEM
    ex(1, 5'd8, 1, 0, 64'h88, 0, 0);
    push(5'd8, 64'h88);
    tick();
    ex(0, 5'd0, 0, 0, 64'd0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stl_rd_mem%0d", k), 64'(bus.rd_mem), 64'd8);
      chk($sformatf("stl_we_wb%0d", k), 64'(bus.reg_write_wb), 64'd0);
      chk($sformatf("stl_lus%0d", k), 64'(bus.load_use_stall), 64'd1);
    end
    idle();
    tick();
    chk("stl_rel_rd_wb", 64'(bus.rd_wb), 64'd8);
    chk("stl_rel_we_wb", 64'(bus.reg_write_wb), 64'd1);
    tick();
    chk("stl_once", 64'(bus.reg_write_wb), 64'd0);
    tick();
    chk("stl_cnt", 64'(bus.retired_writes), 64'(exp_writes));

    // flush of x9
    ex(1, 5'd9, 1, 0, 64'h99, 1, 0);
    tick();
    chk("fl_we_mem", 64'(bus.reg_write_mem), 64'd0);
    idle();
    tick();
    chk("fl_we_wb", 64'(bus.reg_write_wb), 64'd0);
    tick();

    // flush during stall is ignored, then x11 re-presented
    ex(1, 5'd10, 1, 0, 64'hAA, 0, 0);
    push(5'd10, 64'hAA);
    tick();
    ex(1, 5'd11, 1, 0, 64'hBB, 1, 1);
    tick();
    chk("flst_rd_mem", 64'(bus.rd_mem), 64'd10);
    chk("flst_we_mem", 64'(bus.reg_write_mem), 64'd1);
    chk("flst_fwd", bus.fwd_data_mem, 64'hAA);
    ex(1, 5'd11, 1, 0, 64'hBB, 0, 0);
    push(5'd11, 64'hBB);
    tick();
    chk("flst_rd_mem2", 64'(bus.rd_mem), 64'd11);
    idle();
    tick();
    tick();
    chk("flst_cnt", 64'(bus.retired_writes), 64'(exp_writes));

    // async reset mid-cycle with writes in MEM and WB, while stalled
    ex(1, 5'd12, 1, 0, 64'hC12, 0, 0);
    push(5'd12, 64'hC12);
    tick();
    ex(1, 5'd13, 1, 0, 64'hC13, 0, 0);
    tick();
    ex(0, 5'd0, 0, 0, 64'd0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("arst");
    exp_writes = 0;
    idle();
    #2;
    rst = 1'b0;
    tick();
    chk("arst_we_wb", 64'(bus.reg_write_wb), 64'd0);
    chk("arst_rd_mem", 64'(bus.rd_mem), 64'd0);
    chk("arst_lus", 64'(bus.load_use_stall), 64'd0);
    tick();
    chk("arst_cnt", 64'(bus.retired_writes), 64'd0);

    // 17 writes: wraps the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      ex(1, 5'(i + 1), 1, 0, 64'(i) + 64'h500, 0, 0);
      push(5'(i + 1), 64'(i) + 64'h500);
      tick();
    end
    idle();
    tick();
    tick();
    chk("wrap_cnt32", 64'(bus.retired_writes), 64'(exp_writes));
    chk("wrap_cnt4", 64'(bsm.retired_writes), 64'(exp_writes % 16));
    chk("wrap_cnt4_val", 64'(bsm.retired_writes), 64'd1);

    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule

// File: doc/result_track_pipe.md
Name: result_track_pipe

Overview:
- Producer side of the operand-forwarding interface in the 5-stage RV64I pipeline.
- Implements the EX/MEM and MEM/WB destination-tracking registers, which drive rd_mem/reg_write_mem/rd_wb/reg_write_wb plus the matching data to the forwarding consumer.
- Also drives the register-file write port, detects load-use hazards for decode, and counts retired register writes.

Parameters:
XLEN, 64, datapath width
REG_ADDR_W, 5, register index width
CNT_W, 32, retired-write counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
ex_valid  in  1  instruction in EX is valid
rd_ex  in  REG_ADDR_W  destination of EX instruction
reg_write_ex  in  1  EX instruction writes rd
mem_read_ex  in  1  EX instruction is a load
alu_result_ex  in  XLEN  EX result or address
load_data_mem  in  XLEN  load data, valid in MEM when not stall_mem
stall_mem  in  1  hold MEM stage (data-memory wait)
flush_ex  in  1  kill instruction leaving EX
rs1_id  in  REG_ADDR_W  decode source 1
rs2_id  in  REG_ADDR_W  decode source 2
rd_mem  out  REG_ADDR_W  MEM-stage destination
reg_write_mem  out  1  MEM-stage write pending
mem_read_mem  out  1  MEM-stage instruction is a load
fwd_data_mem  out  XLEN  MEM-stage ALU result for forwarding
rd_wb  out  REG_ADDR_W  WB-stage destination
reg_write_wb  out  1  WB-stage write pending
wb_data  out  XLEN  WB-stage result, which also serves as register-file write data
load_use_stall  out  1  decode must stall one cycle
retired_writes  out  CNT_W  count of committed register writes

Behaviour:
- Reset, asynchronous, asserted on rst high:
  - All outputs 0, including retired_writes.
  - Any in-flight instruction is discarded with no partial write.
- MEM register update, each clk edge when stall_mem=0:
  - rd_mem <= rd_ex.
  - reg_write_mem <= ex_valid & reg_write_ex & ~flush_ex & (rd_ex!=0).
  - mem_read_mem <= ex_valid & mem_read_ex & ~flush_ex.
  - fwd_data_mem <= alu_result_ex.
- When stall_mem=1, all MEM registers hold.
- flush_ex is ignored while stall_mem=1; the EX stage must hold its instruction and re-present it.
- WB register update, each clk edge:
  - If stall_mem=0: rd_wb <= rd_mem, reg_write_wb <= reg_write_mem, wb_data <= (mem_read_mem ? load_data_mem : fwd_data_mem).
  - If stall_mem=1: a bubble is inserted. reg_write_wb <= 0; rd_wb and wb_data hold.
- Write suppression:
  - reg_write_mem and reg_write_wb are never 1 with rd==0.
  - The forwarding consumer may rely on this, but still re-checks it.
- Latency: a result seen in EX at cycle N appears on MEM outputs at N+1 and on WB outputs at N+2, assuming no stalls.
- Register-file write: occurs while reg_write_wb=1, one write per cycle the flag is high.
- retired_writes:
  - Increments by 1 on every clk edge where reg_write_wb=1.
  - Wraps modulo 2^CNT_W with no saturation.
- load_use_stall is combinational:
  - Equals ex_valid & mem_read_ex & reg_write_ex & (rd_ex!=0) & ((rd_ex==rs1_id)|(rd_ex==rs2_id)).
  - Must also be 1 whenever stall_mem=1, so decode freezes.
  - flush_ex=1 forces it to 0 unless stall_mem=1.
- Forwarding restriction: fwd_data_mem is the ALU value.
  - When mem_read_mem=1, the consumer must not forward from MEM.
  - load_use_stall guarantees that case never arises for dependent instructions.
- Simultaneous stall_mem and flush_ex: the stall wins. MEM holds; the flush takes effect on the first unstalled edge only if still asserted then.
- Reset mid-stall: the pipeline clears and the stall state is not retained.

Test Plan:
- Back-to-back ALU writes x5=0x11, x6=0x22 at cycles 0,1 -> rd_mem=5/reg_write_mem=1 at cycle 1; rd_wb=5, wb_data=0x11 at cycle 2; rd_wb=6, wb_data=0x22 at cycle 3; retired_writes=2 after cycle 4.
- rd_ex=0 with reg_write_ex=1 -> reg_write_mem=0 and reg_write_wb=0 in all cycles; retired_writes unchanged.
- Load x7 in EX with rs1_id=7 -> load_use_stall=1 that cycle. With load_data_mem=0xDEAD_BEEF_0000_0001, wb_data equals that value two cycles later, not the address.
- stall_mem=1 for 3 cycles with x8 in MEM -> rd_mem=8 held; reg_write_wb=0 for 3 cycles; on release x8 reaches WB exactly once; retired_writes increments by 1.
- flush_ex=1 on a write to x9 -> reg_write_mem=0 next cycle and x9 is never written. flush_ex with stall_mem=1 -> MEM contents unchanged.
- Assert rst asynchronously mid-cycle with writes in MEM and WB -> all outputs 0 immediately, before the next edge; counter 0; preset retired_writes=0xFFFF_FFFF plus one write -> wraps to 0.
